vector_pc: RTL and testbench

//   Program counter for the vector display engine. Holds the 12-bit word address of the

---
 rtl/vec_pkg.sv | 21 ++
 rtl/vec_ret_stack.sv | 45 ++++
 rtl/vector_pc.sv | 62 ++++++
 tb/tb_vector_pc.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector display engine program counter.
//   AW       : word-address width of the PC
//   DEPTH    : return-stack entries (power of two)
//   PTR_W    : stack-pointer width, log2(DEPTH)
//   vec_op_e : long-form vector opcodes that drive call/return/jump
package vec_pkg;

    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    typedef logic [AW-1:0] waddr_t;

    // load_pc = ~opcode[0] is derived upstream from these encodings
    typedef enum logic [3:0] {
        OP_JSRL = 4'hC,
        OP_RTSL = 4'hD,
        OP_JMPL = 4'hE
    } vec_op_e;

endpackage

// File: rtl/vec_ret_stack.sv
// Circular return-address stack (DEPTH x AW) for vector subroutine calls.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset (clears sp and entries)
//   i_push       : write i_data at sp, sp+1
//   i_pop        : sp-1; top entry is presented on o_top_c
//   i_data       : value to push (current PC)
//   o_top_c      : combinational read of stack[sp-1]
// Push and pop together rewrite stack[sp-1] in place and leave sp unchanged.
module vec_ret_stack
    import vec_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_push,
    input  logic   i_pop,
    input  waddr_t i_data,
    output waddr_t o_top_c
);

    waddr_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_sp;
    logic [PTR_W-1:0] w_sp_dec;

    // Pointer wraps mod DEPTH, so pop at sp=0 reads the last entry
    assign w_sp_dec = r_sp - PTR_W'(1);
    assign o_top_c  = r_mem[w_sp_dec];

    // Stack storage and pointer update
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sp <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && i_pop) begin
            r_mem[w_sp_dec] <= i_data;
        end else if (i_push) begin
            r_mem[r_sp] <= i_data;
            r_sp        <= r_sp + PTR_W'(1);
        end else if (i_pop) begin
            r_sp <= w_sp_dec;
        end
    end

endmodule

// File: rtl/vector_pc.sv
// Program counter for the vector display engine with call/return stack.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   latch0/2     : instruction word complete, advance PC by one
//   dmapush      : push current count_out onto the return stack
//   dmaload      : load PC from count_in (load_pc=1) or pop the stack (load_pc=0)
//   load_pc      : selects jump/call target vs. return address
//   count_in     : jump/call target word address
//   count_out    : registered current word address
module vector_pc
    import vec_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          latch0,
    input  logic          latch2,
    input  logic          dmapush,
    input  logic          dmaload,
    input  logic          load_pc,
    input  logic [AW-1:0] count_in,
    output logic [AW-1:0] count_out
);

    waddr_t r_count;
    waddr_t w_count_nxt;
    waddr_t w_stack_top;
    logic   w_pop;

    assign w_pop = dmaload & ~load_pc;

    // Stack always sees the pre-update PC as push data
    vec_ret_stack u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (dmapush),
        .i_pop   (w_pop),
        .i_data  (r_count),
        .o_top_c (w_stack_top)
    );

    // Next-PC select: load beats increment beats hold
    always_comb begin
        w_count_nxt = r_count;
        if (dmaload) begin
            w_count_nxt = load_pc ? count_in : w_stack_top;
        end else if (latch0 || latch2) begin
            w_count_nxt = r_count + AW'(1);
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign count_out = r_count;

endmodule

// File: tb/tb_vector_pc.sv
// Randomized + directed bench for vector_pc with a queue-based scoreboard.
module tb_vector_pc;

    logic        clk;
    logic        reset_n;
    logic        latch0;
    logic        latch2;
    logic        dmapush;
    logic        dmaload;
    logic        load_pc;
    logic [11:0] count_in;
    logic [11:0] count_out;

    int checks   = 0;
    int failures = 0;

    // Reference model state: PC value and a 4-entry circular return stack
    logic [11:0] m_pc;
    logic [11:0] m_stk [4];
    int          m_sp;

    logic [11:0] exp_q [$];
    string       name_q [$];

    vector_pc dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .latch0    (latch0),
        .latch2    (latch2),
        .dmapush   (dmapush),
        .dmaload   (dmaload),
        .load_pc   (load_pc),
        .count_in  (count_in),
        .count_out (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and predict count_out after the next posedge
    task automatic step(input string nm, input bit rn, input bit l0, input bit l2,
                        input bit push, input bit load, input bit lpc,
                        input logic [11:0] cin);
        logic [11:0] old_pc;
        int          top;
        @(negedge clk);
        reset_n  = rn;
        latch0   = l0;
        latch2   = l2;
        dmapush  = push;
        dmaload  = load;
        load_pc  = lpc;
        count_in = cin;
        if (!rn) begin
            m_pc = 12'h000;
            m_sp = 0;
            for (int i = 0; i < 4; i++) m_stk[i] = 12'h000;
        end else begin
            old_pc = m_pc;
            top    = (m_sp + 3) % 4;
            if (load && lpc) begin
                m_pc = cin;
                if (push) begin
                    m_stk[m_sp] = old_pc;
                    m_sp = (m_sp + 1) % 4;
                end
            end else if (load) begin
                m_pc = m_stk[top];
                if (push) m_stk[top] = old_pc;
                else      m_sp = top;
            end else begin
                if (l0 || l2) m_pc = 12'((int'(old_pc) + 1) % 4096);
                if (push) begin
                    m_stk[m_sp] = old_pc;
                    m_sp = (m_sp + 1) % 4;
                end
            end
        end
        exp_q.push_back(m_pc);
        name_q.push_back(nm);
    endtask

    // Monitor: count_out is valid every cycle; compare against queued predictions
    initial begin
        logic [11:0] e;
        string       n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (count_out !== e) begin
                    failures++;
                    $display("FAIL %s: count_out=%03h expected=%03h at %0t", n, count_out, e, $time);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; latch0 = 1'b0; latch2 = 1'b0; dmapush = 1'b0;
        dmaload = 1'b0; load_pc = 1'b0; count_in = 12'h000;
        m_pc = 12'h000; m_sp = 0;
        for (int i = 0; i < 4; i++) m_stk[i] = 12'h000;

        // Reset held with latch0 active, then pop of a cleared stack
        repeat (3) step("reset_latch0", 0, 1, 0, 0, 0, 0, 12'h000);
        step("pop_after_reset", 1, 0, 0, 0, 1, 0, 12'h000);

        // Increment and wrap
        step("reset2", 0, 0, 0, 0, 0, 0, 12'h000);
        repeat (5) step("inc_latch0", 1, 1, 0, 0, 0, 0, 12'h000);
        repeat (5) step("inc_latch2", 1, 0, 1, 0, 0, 0, 12'h000);
        step("inc_both", 1, 1, 1, 0, 0, 0, 12'h000);
        step("load_fff", 1, 0, 0, 0, 1, 1, 12'hFFF);
        step("wrap", 1, 0, 1, 0, 0, 0, 12'h000);

        // Single-cycle call and return
        step("load_010", 1, 0, 0, 0, 1, 1, 12'h010);
        step("call_400", 1, 0, 0, 1, 1, 1, 12'h400);
        repeat (3) step("sub_inc", 1, 1, 0, 0, 0, 0, 12'h000);
        step("return", 1, 0, 0, 0, 1, 0, 12'h000);

        // Nested: four pushes then four pops
        step("reset3", 0, 0, 0, 0, 0, 0, 12'h000);
        for (int k = 1; k <= 4; k++) begin
            step("nest_load", 1, 0, 0, 0, 1, 1, 12'(k));
            step("nest_push", 1, 0, 0, 1, 0, 0, 12'h000);
        end
        repeat (4) step("nest_pop", 1, 0, 0, 0, 1, 0, 12'h000);

        // Overflow: five pushes, oldest overwritten
        step("reset4", 0, 0, 0, 0, 0, 0, 12'h000);
        for (int k = 1; k <= 5; k++) begin
            step("ovf_load", 1, 0, 0, 0, 1, 1, 12'(k));
            step("ovf_push", 1, 0, 0, 1, 0, 0, 12'h000);
        end
        repeat (5) step("ovf_pop", 1, 0, 0, 0, 1, 0, 12'h000);

        // Priority and the push+pop corner
        step("prio_load", 1, 1, 0, 0, 1, 1, 12'h123);
        step("prio_reset", 0, 1, 0, 1, 1, 1, 12'h456);
        step("pp_load", 1, 0, 0, 0, 1, 1, 12'h0AB);
        step("pp_push", 1, 0, 0, 1, 0, 0, 12'h000);
        step("pp_load2", 1, 0, 0, 0, 1, 1, 12'h0CD);
        step("push_pop", 1, 1, 0, 1, 1, 0, 12'h000);
        step("pop_after_pp", 1, 0, 0, 0, 1, 0, 12'h000);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            bit          rn, l0, l2, push, load, lpc;
            logic [11:0] cin;
            rn   = ($urandom_range(0, 59) != 0);
            l0   = ($urandom_range(0, 2) == 0);
            l2   = ($urandom_range(0, 2) == 0);
            push = ($urandom_range(0, 4) == 0);
            load = ($urandom_range(0, 3) == 0);
            lpc  = ($urandom_range(0, 1) == 0);
            cin  = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
            step("random", rn, l0, l2, push, load, lpc, cin);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
